// File: rtl/rca_share_arbiter_if.sv
// Bundles the requester handshakes and the shared-adder connection of rca_share_arbiter.
interface rca_share_arbiter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             gnt0;
  logic             done0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt1;
  logic             done1;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic [WIDTH:0]   res;
  logic             busy;

  // The environment side: operand sources plus the combinational adder result.
  modport master (
    output req0, a0, b0, req1, a1, b1, add_s, add_cout,
    input  gnt0, done0, gnt1, done1, add_a, add_b, res, busy
  );

  // The arbiter side.
  modport slave (
    input  req0, a0, b0, req1, a1, b1, add_s, add_cout,
    output gnt0, done0, gnt1, done1, add_a, add_b, res, busy
  );
endinterface

// File: rtl/rca_share_arbiter.sv
// Round-robin sharing of one ripple-carry adder between two requesters.
// Operands are driven from registers; {cout,s} is captured after ADD_LAT settle cycles.
module rca_share_arbiter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned ADD_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  rca_share_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             lastQ, lastD;
  logic             ownQ, ownD;
  logic [1:0]       armedQ, armedD;
  logic [WIDTH-1:0] addAQ, addAD, addBQ, addBD;
  logic [WIDTH:0]   resQ, resD;
  logic             gnt0Q, gnt0D, gnt1Q, gnt1D;
  logic             done0Q, done0D, done1Q, done1D;
  logic             busyQ, busyD;
  logic [1:0]       reqV;
  logic [1:0]       elig;
  logic             win;

  assign reqV = {bus.req1, bus.req0};

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      lastQ  <= 1'b1;
      ownQ   <= 1'b0;
      armedQ <= 2'b11;
      addAQ  <= '0;
      addBQ  <= '0;
      resQ   <= '0;
      gnt0Q  <= 1'b0;
      gnt1Q  <= 1'b0;
      done0Q <= 1'b0;
      done1Q <= 1'b0;
      busyQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      lastQ  <= lastD;
      ownQ   <= ownD;
      armedQ <= armedD;
      addAQ  <= addAD;
      addBQ  <= addBD;
      resQ   <= resD;
      gnt0Q  <= gnt0D;
      gnt1Q  <= gnt1D;
      done0Q <= done0D;
      done1Q <= done1D;
      busyQ  <= busyD;
    end
  end

  // Next-state, arbitration and next-output logic.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    lastD  = lastQ;
    ownD   = ownQ;
    armedD = armedQ | ~reqV;   // any cycle with req low re-arms that requester
    addAD  = addAQ;
    addBD  = addBQ;
    resD   = resQ;
    elig   = reqV & armedQ;
    win    = 1'b0;

    unique case (stateQ)
      IDLE: begin
        if (elig != 2'b00) begin
          win         = (elig == 2'b11) ? ~lastQ : elig[1];
          stateD      = WAIT;
          cntD        = '0;
          lastD       = win;
          ownD        = win;
          armedD[win] = 1'b0;
          addAD       = win ? bus.a1 : bus.a0;
          addBD       = win ? bus.b1 : bus.b0;
        end
      end
      WAIT: begin
        if (!reqV[ownQ]) begin
          stateD = IDLE;                 // owner withdrew: abort silently
        end else if (cntQ == CNT_W'(ADD_LAT - 1)) begin
          resD   = {bus.add_cout, bus.add_s};
          stateD = DONE;
        end else begin
          cntD = cntQ + CNT_W'(1);
        end
      end
      DONE: stateD = IDLE;
      default: stateD = IDLE;
    endcase

    gnt0D  = (stateD != IDLE) & ~ownD;
    gnt1D  = (stateD != IDLE) & ownD;
    done0D = (stateD == DONE) & ~ownD;
    done1D = (stateD == DONE) & ownD;
    busyD  = (stateD != IDLE);
  end

  assign bus.gnt0  = gnt0Q;
  assign bus.gnt1  = gnt1Q;
  assign bus.done0 = done0Q;
  assign bus.done1 = done1Q;
  assign bus.add_a = addAQ;
  assign bus.add_b = addBQ;
  assign bus.res   = resQ;
  assign bus.busy  = busyQ;
endmodule
